// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU between two requesters; 3 cycles per op (accept, issue, respond).
// Backpressure: a held response stalls the FSM in RESP and blocks new grants until rsp_ready.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [SELW-1:0]  req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [SELW-1:0]  req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_Y,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [7:0]       ops_done,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_Y
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [SELW-1:0] SEL_MAX = SELW'(4);

  state_t           state;
  logic             last;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SELW-1:0]  op_sel;
  logic             op_id;
  logic             gnt0;
  logic             gnt1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last);
    gnt1 = req1_valid && (!req0_valid || !last);
    req0_ready = !rst && (state == IDLE) && gnt0;
    req1_ready = !rst && (state == IDLE) && gnt1;
  end

  // Op registers only change on a request handshake, so they also hold the ALU inputs steady outside ISSUE.
  assign alu_A   = op_a;
  assign alu_B   = op_b;
  assign alu_sel = op_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_Y     <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      ops_done  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op_a   <= req0_A;
            op_b   <= req0_B;
            op_sel <= req0_sel;
            op_id  <= 1'b0;
            state  <= ISSUE;
          end else if (req1_ready) begin
            op_a   <= req1_A;
            op_b   <= req1_B;
            op_sel <= req1_sel;
            op_id  <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_sel <= SEL_MAX) begin
            rsp_Y   <= alu_Y;
            rsp_err <= 1'b0;
          end else begin
            rsp_Y   <= '0;
            rsp_err <= 1'b1;
          end
          rsp_id    <= op_id;
          last      <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
